// File: rtl/counter_run_ctrl.sv
// Run controller for the counter datapath: owns Q, steps it toward a programmed
// end value at a prescaled rate, with hold/abort/restart and one-shot or auto-reload end handling.
module counter_run_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             finished,
    output logic             tick,
    output logic             done,
    output logic             wrap
);

    localparam int             PW       = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] start_v;
        logic [WIDTH-1:0] end_v;
        logic             dir;
        logic             ar;
    } cfg_t;

    state_t           state, state_n;
    cfg_t             cfg, cfg_n;
    logic [PW-1:0]    pre, pre_n;
    logic [WIDTH-1:0] q_n, q_step;
    logic             tick_n, done_n, wrap_n;
    logic             step_en;

    assign step_en = (state == RUN) && !hold && (pre == PRE_LAST);
    assign q_step  = cfg.dir ? Q + WIDTH'(1) : Q - WIDTH'(1);

    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        pre_n   = pre;
        q_n     = Q;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        wrap_n  = 1'b0;

        if (stop) begin
            // stop also swallows a simultaneous start; in IDLE it is a no-op
            state_n = IDLE;
            pre_n   = '0;
        end else if (start) begin
            cfg_n   = '{start_v: start_val, end_v: end_val, dir: dir, ar: auto_reload};
            q_n     = start_val;
            pre_n   = '0;
            if (start_val == end_val && !auto_reload) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state == RUN && !hold) begin
            if (step_en) begin
                pre_n  = '0;
                tick_n = 1'b1;
                if (Q != cfg.end_v) begin
                    q_n = q_step;
                    if (q_step == cfg.end_v && !cfg.ar) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    // sitting on end_v in RUN only happens in auto-reload mode
                    q_n    = cfg.start_v;
                    wrap_n = 1'b1;
                end
            end else begin
                pre_n = pre + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cfg      <= '0;
            pre      <= '0;
            Q        <= '0;
            busy     <= 1'b0;
            finished <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            cfg      <= cfg_n;
            pre      <= pre_n;
            Q        <= q_n;
            busy     <= (state_n == RUN);
            finished <= (state_n == DONE);
            tick     <= tick_n;
            done     <= done_n;
            wrap     <= wrap_n;
        end
    end

endmodule
